// File: rtl/frogger_gfx_pkg.sv
// Shared graphics constants and types for the frogger video path.
// Screen geometry, palette and the blitter state encoding.
package frogger_gfx_pkg;

    localparam int COLOR_W  = 3;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    localparam logic [COLOR_W-1:0] C_BLACK   = 3'b000;
    localparam logic [COLOR_W-1:0] C_BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] C_GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] C_CYAN    = 3'b011;
    localparam logic [COLOR_W-1:0] C_RED     = 3'b100;
    localparam logic [COLOR_W-1:0] C_MAGENTA = 3'b101;
    localparam logic [COLOR_W-1:0] C_YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] C_WHITE   = 3'b111;
    localparam logic [COLOR_W-1:0] C_KEY     = C_MAGENTA;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } blit_state_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register that carries pixel metadata alongside
// the sprite memory read; every stage clears on reset.
module pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = clk ^ reset;
        assign q = d;
    end else begin : g_regs
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite drawing engine: streams a row-major sprite out of sprite memory
// to the VGA write port with colour-key transparency and screen clipping.
module sprite_blitter #(
    parameter int WIDTH_X     = 9,
    parameter int WIDTH_Y     = 9,
    parameter int SCREEN_W    = frogger_gfx_pkg::SCREEN_W,
    parameter int SCREEN_H    = frogger_gfx_pkg::SCREEN_H,
    parameter int COLOR_W     = frogger_gfx_pkg::COLOR_W,
    parameter int ADDR_W      = 15,
    parameter int RAM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH_X:0]   org_x,
    input  logic [WIDTH_Y:0]   org_y,
    input  logic [WIDTH_X-1:0] spr_w,
    input  logic [WIDTH_Y-1:0] spr_h,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               key_en,
    input  logic [COLOR_W-1:0] key_color,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [COLOR_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               plot,
    output logic [WIDTH_X-1:0] x,
    output logic [WIDTH_Y-1:0] y,
    output logic [COLOR_W-1:0] color
);
    import frogger_gfx_pkg::*;

    localparam int SX_W    = WIDTH_X + 2;
    localparam int SY_W    = WIDTH_Y + 2;
    localparam int META_W  = 1 + SX_W + SY_W;
    localparam int DRAIN_W = $clog2(RAM_LATENCY + 1);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RAM_LATENCY - 1);
    localparam logic [SX_W-1:0]    CLIP_X     = SX_W'(SCREEN_W);
    localparam logic [SY_W-1:0]    CLIP_Y     = SY_W'(SCREEN_H);

    blit_state_t state;

    logic [WIDTH_X:0]   org_x_r;
    logic [WIDTH_Y:0]   org_y_r;
    logic [WIDTH_X-1:0] w_r;
    logic [WIDTH_Y-1:0] h_r;
    logic               key_en_r;
    logic [COLOR_W-1:0] key_color_r;
    logic [WIDTH_X-1:0] cx;
    logic [WIDTH_Y-1:0] cy;
    logic [DRAIN_W-1:0] dcnt;

    logic x_last;
    logic y_last;
    logic zero_size;

    assign x_last    = (cx == w_r - WIDTH_X'(1));
    assign y_last    = (cy == h_r - WIDTH_Y'(1));
    assign zero_size = (spr_w == '0) || (spr_h == '0);

    // Control: cx/cy and rd_addr always name the pixel being read this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_addr     <= '0;
            org_x_r     <= '0;
            org_y_r     <= '0;
            w_r         <= '0;
            h_r         <= '0;
            key_en_r    <= 1'b0;
            key_color_r <= '0;
            cx          <= '0;
            cy          <= '0;
            dcnt        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        org_x_r     <= org_x;
                        org_y_r     <= org_y;
                        w_r         <= spr_w;
                        h_r         <= spr_h;
                        key_en_r    <= key_en;
                        key_color_r <= key_color;
                        cx          <= '0;
                        cy          <= '0;
                        dcnt        <= '0;
                        busy        <= 1'b1;
                        if (zero_size) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_SCAN;
                            rd_addr <= base_addr;
                        end
                    end
                end
                ST_SCAN: begin
                    if (x_last && y_last) begin
                        state <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (x_last) begin
                            cx <= '0;
                            cy <= cy + WIDTH_Y'(1);
                        end else begin
                            cx <= cx + WIDTH_X'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DRAIN_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic [SX_W-1:0]   sx;
    logic [SY_W-1:0]   sy;
    logic [META_W-1:0] meta_d;
    logic [META_W-1:0] meta_q;
    logic              p_valid;
    logic [SX_W-1:0]   p_sx;
    logic [SY_W-1:0]   p_sy;

    assign sx     = SX_W'(org_x_r) + SX_W'(cx);
    assign sy     = SY_W'(org_y_r) + SY_W'(cy);
    assign meta_d = {state == ST_SCAN, sx, sy};

    // The rd_addr register already accounts for one cycle of read latency.
    pipe_delay #(
        .WIDTH (META_W),
        .DEPTH (RAM_LATENCY - 1)
    ) u_meta_delay (
        .clk   (clk),
        .reset (reset),
        .d     (meta_d),
        .q     (meta_q)
    );

    assign {p_valid, p_sx, p_sy} = meta_q;

    logic on_screen;
    logic transparent;

    assign on_screen   = (p_sx < CLIP_X) && (p_sy < CLIP_Y);
    assign transparent = key_en_r && (rd_data == key_color_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            plot  <= 1'b0;
            x     <= '0;
            y     <= '0;
            color <= '0;
        end else begin
            plot <= p_valid && on_screen && !transparent;
            if (p_valid) begin
                x     <= p_sx[WIDTH_X-1:0];
                y     <= p_sy[WIDTH_Y-1:0];
                color <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: one instance at read latency 1,
// a second at read latency 2, sharing a behavioural sprite memory.
module tb_sprite_blitter;

    localparam int WX = 9;
    localparam int WY = 9;
    localparam int CW = 3;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start1, start2;
    logic [WX:0]   org_x;
    logic [WY:0]   org_y;
    logic [WX-1:0] spr_w;
    logic [WY-1:0] spr_h;
    logic [AW-1:0] base_addr;
    logic          key_en;
    logic [CW-1:0] key_color;

    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [CW-1:0] rd_data1, rd_data2;
    logic          busy1, busy2, done1, done2, plot1, plot2;
    logic [WX-1:0] x1, x2;
    logic [WY-1:0] y1, y2;
    logic [CW-1:0] color1, color2;

    logic [CW-1:0] mem [0:(1<<AW)-1];

    // rd_addr is registered, so its data arrives RAM_LATENCY-1 cycles after it shows
    assign rd_data1 = mem[rd_addr1];
    always @(posedge clk) rd_data2 <= mem[rd_addr2];

    sprite_blitter #(.RAM_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start1),
        .org_x(org_x), .org_y(org_y), .spr_w(spr_w), .spr_h(spr_h),
        .base_addr(base_addr), .key_en(key_en), .key_color(key_color),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1),
        .plot(plot1), .x(x1), .y(y1), .color(color1)
    );

    sprite_blitter #(.RAM_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .org_x(org_x), .org_y(org_y), .spr_w(spr_w), .spr_h(spr_h),
        .base_addr(base_addr), .key_en(key_en), .key_color(key_color),
        .rd_addr(rd_addr2), .rd_data(rd_data2),
        .busy(busy2), .done(done2),
        .plot(plot2), .x(x2), .y(y2), .color(color2)
    );

    int passed = 0;
    int total  = 0;
    int ecount = 0;

    always @(posedge clk) ecount <= ecount + 1;

    int            pc1[$], pc2[$];
    logic [20:0]   pv1[$], pv2[$];
    int            d1[$], d2[$];
    logic [AW-1:0] a1[int], a2[int];
    logic          b1[int], b2[int];

    // Cycle c is the period that follows edge c-1.
    always @(negedge clk) begin
        int c;
        c = ecount + 1;
        a1[c] = rd_addr1;
        b1[c] = busy1;
        a2[c] = rd_addr2;
        b2[c] = busy2;
        if (plot1) begin
            pc1.push_back(c);
            pv1.push_back({x1, y1, color1});
        end
        if (plot2) begin
            pc2.push_back(c);
            pv2.push_back({x2, y2, color2});
        end
        if (done1) d1.push_back(c);
        if (done2) d2.push_back(c);
    end

    task automatic launch(input int ox, input int oy, input int w, input int h,
                          input int base, input logic ke, input logic [2:0] kc,
                          input logic second, output int k);
        @(negedge clk);
        if (second) begin
            pc2.delete(); pv2.delete(); d2.delete();
        end else begin
            pc1.delete(); pv1.delete(); d1.delete();
        end
        org_x     = 10'(ox);
        org_y     = 10'(oy);
        spr_w     = 9'(w);
        spr_h     = 9'(h);
        base_addr = 15'(base);
        key_en    = ke;
        key_color = kc;
        if (second) start2 = 1'b1;
        else        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        k = ecount;
    endtask

    task automatic wait_done(input logic second, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = second ? (d2.size() != 0) : (d1.size() != 0);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start1 = 1'b0; start2 = 1'b0;
        org_x = '0; org_y = '0; spr_w = '0; spr_h = '0;
        base_addr = '0; key_en = 1'b0; key_color = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({plot1, busy1, done1} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {plot1, busy1, done1});
        else passed++;
        total++;
        if ({x1, y1, color1} !== 21'd0)
            $display("FAIL reset_pix: got %h want 0", {x1, y1, color1});
        else passed++;
        total++;
        if (rd_addr1 !== 15'd0)
            $display("FAIL reset_addr: got %h want 0", rd_addr1);
        else passed++;
        total++;
        if ({plot2, busy2, done2, rd_addr2} !== 18'd0)
            $display("FAIL reset_dut2: got %h want 0", {plot2, busy2, done2, rd_addr2});
        else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int k, gc;
        logic [20:0] gv;
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{20, 20, 21, 21};
        int ec[4] = '{2, 3, 4, 5};
        launch(10, 20, 2, 2, 50, 1'b0, 3'b000, 1'b0, k);
        wait_done(1'b0, 50);
        total++;
        if (pc1.size() !== 4)
            $display("FAIL basic_count: got %0d want 4", pc1.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            gc = (i < pc1.size()) ? pc1[i] : -1;
            gv = (i < pv1.size()) ? pv1[i] : '0;
            total++;
            if (gc !== k + 2 + i || gv !== {9'(ex[i]), 9'(ey[i]), 3'(ec[i])})
                $display("FAIL basic_plot%0d: got cyc %0d %h want cyc %0d %h", i,
                         gc - k, gv, 2 + i, {9'(ex[i]), 9'(ey[i]), 3'(ec[i])});
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (a1[k+1+i] !== 15'(50 + i))
                $display("FAIL basic_addr%0d: got %0d want %0d", i, a1[k+1+i], 50 + i);
            else passed++;
        end
        total++;
        if (d1.size() !== 1 || d1[0] !== k + 6)
            $display("FAIL basic_done: got n=%0d cyc %0d want n=1 cyc 6",
                     d1.size(), d1.size() ? d1[0] - k : -1);
        else passed++;
        total++;
        if ({b1[k], b1[k+1], b1[k+6], b1[k+7]} !== 4'b0110)
            $display("FAIL basic_busy: got %b want 0110",
                     {b1[k], b1[k+1], b1[k+6], b1[k+7]});
        else passed++;
    endtask

    task automatic test_key();
        int k, gc;
        logic [20:0] gv;
        int ex[2] = '{0, 2};
        int ec[2] = '{2, 7};
        int et[2] = '{2, 4};
        launch(0, 0, 3, 1, 100, 1'b1, 3'b101, 1'b0, k);
        wait_done(1'b0, 50);
        total++;
        if (pc1.size() !== 2)
            $display("FAIL key_count: got %0d want 2", pc1.size());
        else passed++;
        for (int i = 0; i < 2; i++) begin
            gc = (i < pc1.size()) ? pc1[i] : -1;
            gv = (i < pv1.size()) ? pv1[i] : '0;
            total++;
            if (gc !== k + et[i] || gv !== {9'(ex[i]), 9'd0, 3'(ec[i])})
                $display("FAIL key_plot%0d: got cyc %0d %h want cyc %0d %h", i,
                         gc - k, gv, et[i], {9'(ex[i]), 9'd0, 3'(ec[i])});
            else passed++;
        end
        total++;
        if (d1.size() !== 1 || d1[0] !== k + 5)
            $display("FAIL key_done: got n=%0d cyc %0d want n=1 cyc 5",
                     d1.size(), d1.size() ? d1[0] - k : -1);
        else passed++;
    endtask

    task automatic test_clip();
        int k, gc;
        logic [20:0] gv;
        int ex[2] = '{318, 319};
        launch(318, 239, 4, 2, 200, 1'b0, 3'b000, 1'b0, k);
        wait_done(1'b0, 50);
        total++;
        if (pc1.size() !== 2)
            $display("FAIL clip_count: got %0d want 2", pc1.size());
        else passed++;
        for (int i = 0; i < 2; i++) begin
            gc = (i < pc1.size()) ? pc1[i] : -1;
            gv = (i < pv1.size()) ? pv1[i] : '0;
            total++;
            if (gc !== k + 2 + i || gv !== {9'(ex[i]), 9'd239, 3'(i)})
                $display("FAIL clip_plot%0d: got cyc %0d %h want cyc %0d %h", i,
                         gc - k, gv, 2 + i, {9'(ex[i]), 9'd239, 3'(i)});
            else passed++;
        end
        total++;
        if (d1.size() !== 1 || d1[0] !== k + 10)
            $display("FAIL clip_done: got n=%0d cyc %0d want n=1 cyc 10",
                     d1.size(), d1.size() ? d1[0] - k : -1);
        else passed++;
    endtask

    task automatic test_zero();
        int k;
        launch(7, 7, 0, 5, 300, 1'b0, 3'b000, 1'b0, k);
        wait_done(1'b0, 20);
        total++;
        if (d1.size() !== 1 || d1[0] !== k + 1)
            $display("FAIL zero_done: got n=%0d cyc %0d want n=1 cyc 1",
                     d1.size(), d1.size() ? d1[0] - k : -1);
        else passed++;
        total++;
        if ({b1[k], b1[k+1], b1[k+2]} !== 3'b010)
            $display("FAIL zero_busy: got %b want 010", {b1[k], b1[k+1], b1[k+2]});
        else passed++;
        total++;
        if (pc1.size() !== 0)
            $display("FAIL zero_plot: got %0d plots want 0", pc1.size());
        else passed++;
        total++;
        if (a1[k+1] !== 15'd207 || a1[k+3] !== 15'd207)
            $display("FAIL zero_addr: got %0d,%0d want 207,207", a1[k+1], a1[k+3]);
        else passed++;
    endtask

    task automatic test_reset_midblit();
        int k, gc, late;
        logic [20:0] gv;
        launch(5, 5, 10, 10, 0, 1'b0, 3'b000, 1'b0, k);
        while (ecount < k + 37) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({plot1, busy1, done1} !== 3'b000)
            $display("FAIL abort_ctrl: got %b want 000", {plot1, busy1, done1});
        else passed++;
        total++;
        if (rd_addr1 !== 15'd0)
            $display("FAIL abort_addr: got %0d want 0", rd_addr1);
        else passed++;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        late = 0;
        foreach (pc1[i]) if (pc1[i] > k + 38) late++;
        total++;
        if (pc1.size() !== 37 || late !== 0)
            $display("FAIL abort_plots: got %0d (%0d late) want 37 (0 late)",
                     pc1.size(), late);
        else passed++;
        launch(1, 1, 2, 1, 8, 1'b0, 3'b000, 1'b0, k);
        wait_done(1'b0, 50);
        for (int i = 0; i < 2; i++) begin
            gc = (i < pc1.size()) ? pc1[i] : -1;
            gv = (i < pv1.size()) ? pv1[i] : '0;
            total++;
            if (gc !== k + 2 + i || gv !== {9'(1 + i), 9'd1, 3'(i)})
                $display("FAIL fresh_plot%0d: got cyc %0d %h want cyc %0d %h", i,
                         gc - k, gv, 2 + i, {9'(1 + i), 9'd1, 3'(i)});
            else passed++;
        end
        total++;
        if (d1.size() !== 1 || d1[0] !== k + 4)
            $display("FAIL fresh_done: got n=%0d cyc %0d want n=1 cyc 4",
                     d1.size(), d1.size() ? d1[0] - k : -1);
        else passed++;
    endtask

    task automatic test_latency2();
        int k, gc;
        logic [20:0] gv;
        int ex[4] = '{30, 31, 30, 31};
        int ey[4] = '{40, 40, 41, 41};
        int ec[4] = '{6, 7, 0, 1};
        int ea[4] = '{32766, 32767, 0, 1};
        launch(30, 40, 2, 2, 32766, 1'b0, 3'b000, 1'b1, k);
        org_x = 10'd100;
        spr_w = 9'd5;
        base_addr = 15'd0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_done(1'b1, 50);
        repeat (3) @(negedge clk);
        total++;
        if (pc2.size() !== 4)
            $display("FAIL lat2_count: got %0d want 4", pc2.size());
        else passed++;
        for (int i = 0; i < 4; i++) begin
            gc = (i < pc2.size()) ? pc2[i] : -1;
            gv = (i < pv2.size()) ? pv2[i] : '0;
            total++;
            if (gc !== k + 3 + i || gv !== {9'(ex[i]), 9'(ey[i]), 3'(ec[i])})
                $display("FAIL lat2_plot%0d: got cyc %0d %h want cyc %0d %h", i,
                         gc - k, gv, 3 + i, {9'(ex[i]), 9'(ey[i]), 3'(ec[i])});
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (a2[k+1+i] !== 15'(ea[i]))
                $display("FAIL lat2_addr%0d: got %0d want %0d", i, a2[k+1+i], ea[i]);
            else passed++;
        end
        total++;
        if (d2.size() !== 1 || d2[0] !== k + 7)
            $display("FAIL lat2_done: got n=%0d cyc %0d want n=1 cyc 7",
                     d2.size(), d2.size() ? d2[0] - k : -1);
        else passed++;
        total++;
        if ({b2[k+7], b2[k+8], b2[k+10]} !== 3'b100)
            $display("FAIL lat2_busy: got %b want 100", {b2[k+7], b2[k+8], b2[k+10]});
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 3'(i);
        mem[100] = 3'b010;
        mem[101] = 3'b101;
        mem[102] = 3'b111;
        test_reset();
        test_basic();
        test_key();
        test_clip();
        test_zero();
        test_reset_midblit();
        test_latency2();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised sprite drawing engine: on a `start` pulse it rasterises a sprite of run-time size (`spr_w` × `spr_h`) stored at `base_addr` in an external synchronous sprite ROM/RAM. It writes the sprite at a run-time screen origin, with colour-key transparency and clipping to the screen. It sits between the game control FSM and the VGA adapter, and replaces the fixed-size plotter, per-sprite offset muxing and hand-tuned one-cycle delay with one handshaken block.

## Interface
- `WIDTH_X`, 9: screen x coordinate width.
- `WIDTH_Y`, 9: screen y coordinate width.
- `SCREEN_W`, 320: pixels at x ≥ SCREEN_W are clipped.
- `SCREEN_H`, 240: pixels at y ≥ SCREEN_H are clipped.
- `COLOR_W`, 3: colour width.
- `ADDR_W`, 15: sprite memory address width.
- `RAM_LATENCY`, 1: read latency of sprite memory in cycles, ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a blit; sampled only in IDLE.
- `org_x`  in  WIDTH_X+1  sprite top-left x, unsigned; extra bit allows origins past the right edge.
- `org_y`  in  WIDTH_Y+1  sprite top-left y.
- `spr_w`  in  WIDTH_X  sprite width in pixels.
- `spr_h`  in  WIDTH_Y  sprite height in pixels.
- `base_addr`  in  ADDR_W  address of sprite pixel (0,0); row-major storage.
- `key_en`  in  1  enable transparency.
- `key_color`  in  COLOR_W  transparent colour.
- `rd_addr`  out  ADDR_W  sprite memory address.
- `rd_data`  in  COLOR_W  memory data, valid RAM_LATENCY cycles after `rd_addr`.
- `busy`  out  1  blit in progress.
- `done`  out  1  one-cycle pulse at blit completion.
- `plot`, `x` [WIDTH_X], `y` [WIDTH_Y], `color` [COLOR_W]  out  VGA adapter write port.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - With `start`=1, latch all inputs (including `key_en`/`key_color`) and clear counters `cx`, `cy` and address offset.
  - Go to SCAN, or to DONE if `spr_w`==0 or `spr_h`==0.
- SCAN:
  - Issue one pixel per cycle, row-major.
  - `rd_addr` = `base_addr` + running offset, incremented by 1 per pixel, no multiplier, wraps mod 2^ADDR_W.
  - `cx` counts 0..spr_w-1, then returns to 0 with `cy`+1.
  - After issuing pixel (spr_w-1, spr_h-1), go to DRAIN.
- DRAIN: hold RAM_LATENCY cycles while the pipeline empties, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Pipeline:
  - Each issued pixel carries a valid bit, sx = org_x+cx and sy = org_y+cy, computed at full width (WIDTH_X+2 / WIDTH_Y+2 bits, no overflow).
  - These are delayed RAM_LATENCY stages so they align with `rd_data`.
- Output stage, registered:
  - `plot` = valid ∧ sx<SCREEN_W ∧ sy<SCREEN_H ∧ ¬(key_en ∧ rd_data==key_color).
  - `x`, `y`, `color` update on every valid pipeline cycle and are meaningful only when `plot`=1.
- Clipped or transparent pixels take the same cycle slot as drawn pixels. Blit duration does not depend on origin or content.
- `start` while `busy` is ignored; parameters are not re-latched.
- `reset`, at any time including mid-blit:
  - Next state is IDLE and the pipeline is flushed.
  - `plot`, `busy`, `done` go to 0; `x`, `y`, `color`, `rd_addr` go to 0.
  - No further plots from the aborted blit.

## Timing
- `start` sampled at edge k.
- Pixel n (0..N-1, N = spr_w·spr_h) has `rd_addr` valid in cycle k+1+n.
- The matching `plot` is in cycle k+1+n+RAM_LATENCY.
- `busy`=1 from cycle k+1 through the `done` cycle inclusive; 0 in IDLE.
- `done` in cycle k+N+RAM_LATENCY+1.
- Zero-size sprite: `done` in cycle k+1, no plot.
- The next `start` is accepted the cycle after `done`, so the minimum gap between blits is 1 idle cycle.
- Throughput: 1 pixel/cycle; no backpressure.

## Structure
- Shared package `frogger_gfx_pkg`:
  - COLOR_W, SCREEN_W, SCREEN_H.
  - Colour constants, including the default key colour 3'b101.
  - State encoding typedef for the blitter FSM.
- Sub-module `pipe_delay` (parameters WIDTH, DEPTH): shift register for {valid, sx, sy}, reset to 0.

## Test plan
- 2×2 at (10,20), L=1, key off, start at k → plots (10,20),(11,20),(10,21),(11,21) in cycles k+2..k+5; `rd_addr` base..base+3; `done` at k+6.
- 3×1 at (0,0), key_en=1, key_color=3'b101, data {3'b010,3'b101,3'b111} → plots only (0,0)=3'b010 and (2,0)=3'b111; `done` timing unchanged.
- 4×2 at (318,239) → plots only (318,239),(319,239); `done` at k+8+L+1.
- spr_w=0 → `done` at k+1, `busy` for 1 cycle, no plot, no `rd_addr` change.
- 10×10 blit: `reset` at pixel 37 → next cycle `plot`=`busy`=0 and no later plot; a fresh start then completes normally.
- RAM_LATENCY=2, `start` re-pulsed while busy → ignored; colours align with coordinates; `base_addr`=2^15-2 with a 4-pixel sprite wraps to addresses 0,1.
